exc_pipe_ctrl: RTL

Exception/interrupt sequencing controller for the five-stage MIPS pipeline. It carries each in-flight instruction's PC, branch-delay flag and first-detected exception code from D through E to M. It presents that M-stage context to the coprocessor-0 block and turns the coprocessor's request, or an `eret` reaching M, into a pipeline-wide flush plus a PC redirect. It sits beside the hazard unit and owns no CP0 state itself.

---
 rtl/exc_pipe_ctrl.sv | 93 +++++++++
 1 files changed

// File: rtl/exc_pipe_ctrl.sv
// exc_pipe_ctrl: carries exception context D->E->M and turns CP0 requests
// or a committing eret into a pipeline flush plus PC redirect.
module exc_pipe_ctrl #(
  parameter logic [31:0] HANDLER_ADDR = 32'h0000_4180,
  parameter logic [31:0] RESET_PC     = 32'h0000_3000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [31:0] f_pc,
  input  logic [4:0]  f_exc,
  input  logic [4:0]  d_exc,
  input  logic        d_is_branch,
  input  logic        d_eret,
  input  logic [4:0]  e_exc,
  input  logic [4:0]  m_exc,
  input  logic        cp0_req,
  input  logic [31:0] cp0_epc,
  output logic [4:0]  exc_code_m,
  output logic        bd_m,
  output logic [31:0] vpc_m,
  output logic        flush,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        exl_clr
);

  typedef struct packed {
    logic        v;
    logic [31:0] pc;
    logic        bd;
    logic [4:0]  exc;
    logic        er;
  } rec_t;

  rec_t r_d, r_e, r_m;

  logic       w_eret_m;
  logic       w_take_eret;
  logic [4:0] w_exc_e;
  logic [4:0] w_exc_m;

  function automatic rec_t bubble(
    input logic [31:0] pc,
    input logic        bd
  );
    bubble = '{v: 1'b0, pc: pc, bd: bd,
               exc: 5'd0, er: 1'b0};
  endfunction

  // An exception request always beats an eret commit in M.
  assign w_eret_m    = r_m.v & r_m.er;
  assign w_take_eret = w_eret_m & ~cp0_req;

  assign flush       = cp0_req | w_eret_m;
  assign redirect    = flush;
  assign exl_clr     = w_take_eret;
  assign redirect_pc = w_take_eret ? cp0_epc
                                   : HANDLER_ADDR;

  assign w_exc_e = (r_d.exc != 5'd0) ? r_d.exc : d_exc;
  assign w_exc_m = (r_e.exc != 5'd0) ? r_e.exc : e_exc;

  assign exc_code_m = !r_m.v ? 5'd0 :
                      (r_m.exc != 5'd0) ? r_m.exc : m_exc;
  assign bd_m  = r_m.bd;
  assign vpc_m = r_m.pc;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_d <= bubble(RESET_PC, 1'b0);
      r_e <= bubble(RESET_PC, 1'b0);
      r_m <= bubble(RESET_PC, 1'b0);
    end else if (flush) begin
      r_d <= bubble(redirect_pc, 1'b0);
      r_e <= bubble(redirect_pc, 1'b0);
      r_m <= bubble(redirect_pc, 1'b0);
    end else begin
      r_m <= '{v: r_e.v, pc: r_e.pc, bd: r_e.bd,
               exc: w_exc_m, er: r_e.er};
      if (stall) begin
        r_e <= bubble(r_d.pc, r_d.bd);
      end else begin
        r_e <= '{v: r_d.v, pc: r_d.pc, bd: r_d.bd,
                 exc: w_exc_e, er: d_eret & r_d.v};
        r_d <= '{v: 1'b1, pc: f_pc,
                 bd: r_d.v & d_is_branch,
                 exc: f_exc, er: 1'b0};
      end
    end
  end

endmodule
